alu_bit_serial: RTL and testbench

//  Bit-serial ALU engine: latches WIDTH-bit operands, streams them LSB-first one bit
//  per cycle through a single 1-bit ALU slice (AND/OR/ADD/SLT with A/B invert), and

---
 rtl/alu_bit_serial.sv | 171 +++++++++++++++++
 tb/tb_alu_bit_serial.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: one 1-bit slice reused over WIDTH cycles, LSB first.
// Carry is registered between bits; result word assembled by shifting.
//
// alu_slice     : combinational 1-bit ALU cell (AND/OR/ADD/SLT, A/B invert)
// alu_bit_serial:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               request, sampled only while idle
//   src1, src2          operands, latched when start is accepted
//   ALU_control         {Ainvert, Binvert, op[1:0]}, latched with operands
//   busy                high while running and in the done cycle
//   done                one-cycle pulse, outputs valid from this cycle
//   result, zero        final word and result==0, held until next op
//   cout, overflow      MSB carry out, MSB cin^cout (0 for AND/OR)

module alu_slice (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       less,
   input  logic       ainv,
   input  logic       binv,
   input  logic [1:0] op,
   output logic       res,
   output logic       sum,
   output logic       cout
);

   logic aa;
   logic bb;

   assign aa   = a ^ ainv;
   assign bb   = b ^ binv;
   assign sum  = aa ^ bb ^ cin;
   assign cout = (aa & bb) | (aa & cin) | (bb & cin);

   always_comb begin
      res = 1'b0;
      case (op)
         2'b00: res = aa & bb;
         2'b01: res = aa | bb;
         2'b10: res = sum;
         2'b11: res = less;
      endcase
   end

endmodule

module alu_bit_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] r_fin;
   logic [3:0]       ctl;
   logic             cy;
   logic [IW-1:0]    idx;
   logic             last;
   logic             s_res;
   logic             s_sum;
   logic             s_cout;

   alu_slice u_slice (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (cy),
      .less (1'b0),
      .ainv (ctl[3]),
      .binv (ctl[2]),
      .op   (ctl[1:0]),
      .res  (s_res),
      .sum  (s_sum),
      .cout (s_cout)
   );

   assign last  = (idx == IW'(WIDTH - 1));
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

   // Slice outputs enter at the top so bit 0 lands at position 0
   // after WIDTH shifts.
   assign r_nxt = {s_res, r_sh[WIDTH-1:1]};

   // SLT takes the raw subtract sign bit, no overflow correction.
   assign r_fin = (ctl[1:0] == 2'b11)
                ? {{(WIDTH-1){1'b0}}, s_sum}
                : r_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         r_sh     <= '0;
         ctl      <= '0;
         cy       <= 1'b0;
         idx      <= '0;
         result   <= '0;
         zero     <= 1'b1;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= src1;
                  b_sh <= src2;
                  ctl  <= ALU_control;
                  // Binvert doubles as the +1 of two's complement.
                  cy   <= ALU_control[2];
                  idx  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_nxt;
               cy   <= s_cout;
               idx  <= idx + IW'(1);
               if (last) begin
                  result   <= r_fin;
                  zero     <= (r_fin == '0);
                  cout     <= s_cout;
                  overflow <= ctl[1] & (cy ^ s_cout);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bit_serial.sv
// Directed bench for alu_bit_serial (WIDTH=32).
// Vector table plus hand sequences for busy, done-cycle and reset cases.

module tb_alu_bit_serial;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic [3:0]   ctl;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         cout;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   alu_bit_serial #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .src1        (src1),
      .src2        (src2),
      .ALU_control (ctl),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .zero        (zero),
      .cout        (cout),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [3:0]   c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Start is driven just after an edge; lat counts edges from the
   // sampling edge until done is seen (0 if it never came).
   task automatic run_op(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [3:0]   c,
                         output int          lat);
      src1  = a;
      src2  = b;
      ctl   = c;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!done) lat = 0;
   endtask

   int lat;
   logic seen;

   initial begin
      vt[0] = '{"add7p5",  4'b0010, 32'd7, 32'd5,
                32'h0000000C, 1'b0, 1'b0, 1'b0};
      vt[1] = '{"sub5m7",  4'b0110, 32'd5, 32'd7,
                32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vt[2] = '{"slt3_5",  4'b0111, 32'd3, 32'd5,
                32'h00000001, 1'b0, 1'b0, 1'b0};
      vt[3] = '{"slt5_3",  4'b0111, 32'd5, 32'd3,
                32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[4] = '{"slt5_5",  4'b0111, 32'd5, 32'd5,
                32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[5] = '{"addovf",  4'b0010, 32'h7FFFFFFF, 32'd1,
                32'h80000000, 1'b0, 1'b0, 1'b1};
      vt[6] = '{"and",     4'b0000, 32'h0000F0F0, 32'h0000FF00,
                32'h0000F000, 1'b0, 1'b0, 1'b0};
      vt[7] = '{"nor",     4'b1100, 32'd0, 32'd0,
                32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vt[8] = '{"or",      4'b0001, 32'h000000FF, 32'h00000F00,
                32'h00000FFF, 1'b0, 1'b0, 1'b0};
      vt[9] = '{"addwrap", 4'b0010, 32'hFFFFFFFF, 32'd1,
                32'h00000000, 1'b1, 1'b1, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      src1  = '0;
      src2  = '0;
      ctl   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd1);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vt[k]) begin
         run_op(vt[k].a, vt[k].b, vt[k].c, lat);
         chk({vt[k].name, "_lat"}, lat, W + 1);
         chk({vt[k].name, "_res"}, result, vt[k].res);
         chk({vt[k].name, "_zero"}, {31'b0, zero}, {31'b0, vt[k].z});
         chk({vt[k].name, "_cout"}, {31'b0, cout}, {31'b0, vt[k].co});
         chk({vt[k].name, "_ovf"}, {31'b0, overflow}, {31'b0, vt[k].ov});
         @(posedge clk);
         #1;
         chk({vt[k].name, "_pulse"}, {31'b0, done}, 32'd0);
      end

      // start while busy with different operands, operands also changed
      src1  = 32'd7;
      src2  = 32'd5;
      ctl   = 4'b0010;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_mid", {31'b0, busy}, 32'd1);
      src1  = 32'h12345678;
      src2  = 32'h00000100;
      ctl   = 4'b0001;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("ign_done", {31'b0, done}, 32'd1);
      chk("ign_res", result, 32'h0000000C);

      // start held during the done cycle is ignored
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("donecyc_busy", {31'b0, busy}, 32'd0);
      chk("donecyc_res", result, 32'h0000000C);
      @(posedge clk);
      #1;
      chk("donecyc_idle", {31'b0, busy}, 32'd0);

      // reset during RUN at bit 10
      src1  = 32'd100;
      src2  = 32'd23;
      ctl   = 4'b0010;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_res", result, 32'd0);
      chk("abort_zero", {31'b0, zero}, 32'd1);
      chk("abort_done", {31'b0, done}, 32'd0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      chk("abort_nodone", {31'b0, seen}, 32'd0);

      run_op(32'd100, 32'd23, 4'b0010, lat);
      chk("post_lat", lat, W + 1);
      chk("post_res", result, 32'd123);
      chk("post_zero", {31'b0, zero}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
